// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state type and defaults for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_BUSY, ARB_WAIT_DONE} arb_state_t;
  localparam int DEFAULT_BUSY_TIMEOUT = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wraparound
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);
  logic [IW:0] pos;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      pos = (pos >= (IW+1)'(N)) ? pos - (IW+1)'(N) : pos;
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        grant[pos[IW-1:0]] = 1'b1;
        idx = pos[IW-1:0];
      end
    end
    any_req = found;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, one frame per grant,
// with a watchdog on the transmitter's busy handshake
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic                          err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);
  arb_state_t state;
  logic [IW-1:0] rr_ptr, win_idx, next_ptr;
  logic [NUM_REQ-1:0] win_grant;
  logic any_req, accept;
  logic [CW-1:0] cnt;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(win_grant),
    .idx(win_idx),
    .any_req(any_req)
  );
  assign accept = (state == ARB_IDLE) && enable && any_req && !tx_busy;
  assign req_ready = accept ? win_grant : '0;
  assign next_ptr = (grant_id == IW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      rr_ptr <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      grant_id <= '0;
      active <= 1'b0;
      err_timeout <= 1'b0;
      cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ARB_IDLE: if (accept) begin
          tx_data <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          grant_id <= win_idx;
          active <= 1'b1;
          tx_start <= 1'b1;
          state <= ARB_ISSUE;
        end
        ARB_ISSUE: begin
          cnt <= '0;
          state <= ARB_WAIT_BUSY;
        end
        // the counter leaves this state at BUSY_TIMEOUT-1, so it can never wrap
        ARB_WAIT_BUSY: if (tx_busy) state <= ARB_WAIT_DONE;
          else if (cnt == CW'(BUSY_TIMEOUT-1)) begin
            err_timeout <= 1'b1;
            active <= 1'b0;
            rr_ptr <= next_ptr;
            state <= ARB_IDLE;
          end else cnt <= cnt + 1'b1;
        ARB_WAIT_DONE: if (!tx_busy) begin
          active <= 1'b0;
          rr_ptr <= next_ptr;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors and handshake corner cases for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 16;
  logic clk = 0, rst = 1, enable = 1;
  logic tx_busy;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data;
  logic tx_start, active, err_timeout;
  logic [DW-1:0] tx_data;
  logic [1:0] grant_id;
  logic model_busy = 0, force_busy = 0, model_on = 1;
  int busy_delay = 2, busy_len = 5, dly = 0, len = 0;
  int tests = 0, fails = 0;
  typedef struct { logic [N-1:0] mask; int exp_id; } vec_t;
  vec_t vecs[10];

  assign tx_busy = model_busy | force_busy;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  // transmitter model: busy rises busy_delay cycles after tx_start, stays high busy_len cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      model_busy = 0; dly = 0; len = 0;
    end else if (tx_start && model_on) dly = busy_delay;
    else if (dly > 0) begin
      dly--;
      if (dly == 0) begin model_busy = 1; len = busy_len; end
    end else if (len > 0) begin
      len--;
      if (len == 0) model_busy = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'h0010 + 16'(i);
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; force_busy = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (tx_busy == lvl);
    end
    chk(nm, 32'(ok), 1);
  endtask

  task automatic run_frame(input logic [N-1:0] mask, input int exp_id, input string nm);
    bit done = 0;
    req_valid = mask;
    #1;
    chk({nm, ".ready"}, 32'(req_ready), 32'(1 << exp_id));
    @(negedge clk);
    chk({nm, ".start"}, 32'(tx_start), 1);
    chk({nm, ".grant_id"}, 32'(grant_id), 32'(exp_id));
    chk({nm, ".data"}, 32'(tx_data), 32'(16'h0010 + exp_id));
    req_valid = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = !active;
    end
    chk({nm, ".done"}, 32'(done), 1);
  endtask

  initial begin
    bit bad;
    int errs, err_at;
    vecs[0] = '{4'b1111, 0}; vecs[1] = '{4'b1111, 1}; vecs[2] = '{4'b1111, 2};
    vecs[3] = '{4'b1111, 3}; vecs[4] = '{4'b1111, 0}; vecs[5] = '{4'b0100, 2};
    vecs[6] = '{4'b0101, 0}; vecs[7] = '{4'b1010, 1}; vecs[8] = '{4'b1001, 3};
    vecs[9] = '{4'b0110, 1};
    set_data();
    repeat (2) @(negedge clk);
    chk("rst.tx_start", 32'(tx_start), 0);
    chk("rst.tx_data", 32'(tx_data), 0);
    chk("rst.grant_id", 32'(grant_id), 0);
    chk("rst.active", 32'(active), 0);
    chk("rst.err", 32'(err_timeout), 0);
    chk("rst.ready", 32'(req_ready), 0);
    rst = 0;

    for (int v = 0; v < 10; v++) run_frame(vecs[v].mask, vecs[v].exp_id, $sformatf("vec%0d", v));

    do_reset();
    busy_len = 10;
    req_data[2*DW +: DW] = 16'h00A5;
    req_valid = 4'b0100;
    #1;
    chk("a5.ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    chk("a5.start", 32'(tx_start), 1);
    chk("a5.data", 32'(tx_data), 32'h00A5);
    chk("a5.grant_id", 32'(grant_id), 2);
    req_valid = '0;
    req_data = '1;
    @(negedge clk);
    chk("a5.start_one_cycle", 32'(tx_start), 0);
    wait_busy(1, "a5.busy_rise");
    wait_busy(0, "a5.busy_fall");
    chk("a5.active_hold", 32'(active), 1);
    chk("a5.data_hold", 32'(tx_data), 32'h00A5);
    @(negedge clk);
    chk("a5.active_fall", 32'(active), 0);
    set_data();
    busy_len = 5;

    do_reset();
    model_on = 0;
    errs = 0; err_at = 0;
    req_valid = 4'b0011;
    #1;
    chk("to.ready", 32'(req_ready), 32'b0001);
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        errs++; err_at = i;
        chk("to.active", 32'(active), 0);
        chk("to.next_ready", 32'(req_ready), 32'b0010);
      end
      if (errs == 1 && i == err_at + 1) begin
        chk("to.next_grant", 32'(grant_id), 1);
        chk("to.next_start", 32'(tx_start), 1);
      end
    end
    chk("to.pulses", 32'(errs), 1);
    chk("to.window", 32'(err_at >= 17 && err_at <= 18), 1);
    req_valid = '0;
    model_on = 1;

    do_reset();
    req_valid = 4'b1010;
    #1;
    chk("en.ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    wait_busy(1, "en.busy_rise");
    @(negedge clk);
    enable = 0;
    bad = 0;
    begin
      bit done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
        @(negedge clk);
        bad |= (req_ready != 0);
        done = !active;
      end
      chk("en.frame_done", 32'(done), 1);
    end
    repeat (3) begin
      @(negedge clk);
      bad |= (req_ready != 0);
    end
    chk("en.no_ready", 32'(bad), 0);
    enable = 1;
    #1;
    chk("en.resume", 32'(req_ready), 32'b1000);
    @(negedge clk);
    chk("en.resume_id", 32'(grant_id), 3);
    req_valid = '0;

    do_reset();
    force_busy = 1;
    req_valid = 4'b0001;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      bad |= (req_ready != 0);
    end
    chk("busy.no_ready", 32'(bad), 0);
    force_busy = 0;
    #1;
    chk("busy.release", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("busy.start", 32'(tx_start), 1);
    req_valid = '0;

    do_reset();
    run_frame(4'b0001, 0, "pre");
    model_on = 0;
    req_valid = 4'b0100;
    #1;
    chk("mid.ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("mid.active", 32'(active), 1);
    rst = 1;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      bad |= tx_start;
    end
    chk("mid.no_start", 32'(bad), 0);
    chk("mid.tx_data", 32'(tx_data), 0);
    chk("mid.grant_id", 32'(grant_id), 0);
    chk("mid.active_rst", 32'(active), 0);
    chk("mid.err", 32'(err_timeout), 0);
    rst = 0;
    model_on = 1;
    req_valid = 4'b1111;
    #1;
    chk("mid.rr_ptr0", 32'(req_ready), 32'b0001);
    req_valid = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (uart_send-style: start strobe, 16-bit data, busy flag) between NUM_REQ on-chip requesters, e.g. CPU APB path, debug logger, DMA.
- Round-robin arbitration with one frame per grant.
- Sequences the transmitter handshake and detects a transmitter that never goes busy.
- Sits between the requesters and the UART TX datapath in the peripheral subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, frame payload width, matches UART datapath input
BUSY_TIMEOUT, 16, cycles to wait for tx_busy rise after tx_start before abort (>=2)

Ports:
clk  input  1  block clock
rst  input  1  asynchronous reset, active-high
enable  input  1  1 = new grants allowed; 0 = finish in-flight frame, grant nothing new
req_valid  input  NUM_REQ  per-requester frame-valid
req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i] are high in the same cycle
tx_start  output  1  one-cycle start strobe to the transmitter
tx_data  output  DATA_WIDTH  frame to transmit; held stable from tx_start until return to IDLE
tx_busy  input  1  transmitter busy flag
grant_id  output  $clog2(NUM_REQ)  index of the last/current granted requester
active  output  1  high from the accept cycle until the frame completes or aborts
err_timeout  output  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- Reset values: state IDLE, rr_ptr 0, tx_start 0, tx_data 0, grant_id 0, active 0, err_timeout 0, timeout counter 0.
- req_ready is the only combinational output; all other outputs are registered.
- State machine, 4 states:
  - IDLE:
    - req_ready = onehot(winner) when enable & |req_valid & !tx_busy; otherwise 0.
    - Winner: first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    - On accept: latch req_data slice into tx_data, grant_id <= winner, active <= 1, go to ISSUE.
  - ISSUE: tx_start = 1 for exactly this cycle; clear timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy = 1 -> go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0, pulse err_timeout, set active <= 0, rr_ptr <= grant_id+1 mod NUM_REQ, go to IDLE. The frame is dropped and not retried.
  - WAIT_DONE: tx_busy = 0 -> active <= 0, rr_ptr <= grant_id+1 mod NUM_REQ, go to IDLE.
- Latency: accept at cycle N -> tx_start at N+1. Minimum spacing between accepts is 4 cycles plus the transmitter busy time.
- Fairness: after a grant, the granted requester has lowest priority. With all requesters valid, the grant order is 0,1,2,3,0,... from reset.
- enable deasserted mid-frame: the frame completes normally. No accept while enable = 0. rr_ptr is unchanged while idle.
- tx_busy high in IDLE (transmitter owned elsewhere or still draining): no accept.
- req_valid dropped before accept: nothing is captured. Once accepted, the payload is held internally and upstream may change freely.
- Timeout counter width: $clog2(BUSY_TIMEOUT); it saturates and never wraps.
- rst asserted mid-frame: immediate return to reset values. tx_start is never glitched high.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Non-power-of-2 NUM_REQ is legal; indices >= NUM_REQ are never produced.

Decomposition:
- Package uart_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_BUSY, ARB_WAIT_DONE} arb_state_t
  - localparam default BUSY_TIMEOUT
- One sub-module rr_arbiter: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, binary index, any_req.
  - Reusable by future shared-peripheral arbiters.

Test Plan:
- Reset, requester 2 valid with data 16'h00A5, tx_busy rises 2 cycles after tx_start, held 10 cycles -> req_ready[2] in the accept cycle; tx_start one cycle later; tx_data = 16'h00A5; grant_id = 2; active falls the cycle after tx_busy falls.
- All four requesters valid continuously with data 16'h0010+i, transmitter model busy 5 cycles -> accept order 0,1,2,3,0; tx_data sequence 0010,0011,0012,0013,0010.
- tx_busy never rises after tx_start, BUSY_TIMEOUT = 16 -> err_timeout pulses exactly once; state returns to IDLE; the next requester in rotation is granted next.
- enable dropped during WAIT_DONE with requesters 1 and 3 valid -> current frame completes; no req_ready while enable = 0; re-enable -> requester after grant_id granted first.
- tx_busy held high in IDLE with requester 0 valid -> req_ready stays 0. Release tx_busy -> accept on the same cycle tx_busy is seen low.
- rst asserted in WAIT_BUSY -> all outputs at reset values on the next edge; no tx_start; rr_ptr = 0.
